// File: rtl/biriscv_vec_issue_sched_pkg.sv
// Shared types for the vector issue scheduler: FSM encoding and buffered op payload.
package biriscv_vec_issue_sched_pkg;

    typedef enum logic [1:0] {
        VEC_SCHED_IDLE  = 2'd0,
        VEC_SCHED_HOLD  = 2'd1,
        VEC_SCHED_DRAIN = 2'd2
    } vec_sched_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_lsu;
    } vec_op_t;

endpackage

// File: rtl/biriscv_vec_issue_sched_if.sv
// Scheduler <-> vector unit handshake: offered op plus accept/done return path.
interface biriscv_vec_issue_sched_if;

    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_lsu;
    logic        accept;
    logic        done;

    modport master (
        output valid, instr, pc, is_lsu,
        input  accept, done
    );

    modport slave (
        input  valid, instr, pc, is_lsu,
        output accept, done
    );

endinterface

// File: rtl/biriscv_vec_credit.sv
// Outstanding vector-op counter plus the "vector LSU in flight" flag.
module biriscv_vec_credit #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          flag_set_i,
    input  logic          flag_clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          flag_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;

    // A done with nothing outstanding is dropped, so it cannot cancel a same-cycle inc.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(dec_i && cnt_q != '0)) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        flag_d = flag_q;
        if (flag_set_i) begin
            flag_d = 1'b1;
        end else if (flag_clr_i) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/biriscv_vec_issue_sched.sv
// In-order scheduler feeding vector ops from the two decode lanes into one vector unit,
// with an outstanding-op limit and full serialisation around vector loads/stores.
module biriscv_vec_issue_sched
    import biriscv_vec_issue_sched_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,

    input  logic        lane0_valid_i,
    input  logic [31:0] lane0_instr_i,
    input  logic [31:0] lane0_pc_i,
    input  logic        lane0_lsu_v_i,
    input  logic        lane0_alu_v_i,

    input  logic        lane1_valid_i,
    input  logic [31:0] lane1_instr_i,
    input  logic [31:0] lane1_pc_i,
    input  logic        lane1_lsu_v_i,
    input  logic        lane1_alu_v_i,

    output logic        lane0_accept_o,
    output logic        lane1_accept_o,

    biriscv_vec_issue_sched_if.master vec,

    output logic        lsu_busy_o,
    output logic        busy_o
);

    localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    vec_sched_state_e state_q, state_d;
    logic             buf_valid_q, buf_valid_d;
    vec_op_t          buf_q, buf_d;

    logic [CW-1:0]    cnt;
    logic             lsu_inflight_q;

    logic             head_valid;
    logic             head_sel1;
    vec_op_t          head_op;
    logic             take;
    logic             issue;

    // A valid lane 0 always owns the head slot, even when scalar: program order.
    always_comb begin
        head_sel1  = !lane0_valid_i;
        head_valid = 1'b0;
        head_op    = '0;
        if (lane0_valid_i) begin
            head_valid = lane0_lsu_v_i | lane0_alu_v_i;
            head_op    = '{instr: lane0_instr_i, pc: lane0_pc_i, is_lsu: lane0_lsu_v_i};
        end else begin
            head_valid = lane1_valid_i & (lane1_lsu_v_i | lane1_alu_v_i);
            head_op    = '{instr: lane1_instr_i, pc: lane1_pc_i, is_lsu: lane1_lsu_v_i};
        end
    end

    assign issue = buf_valid_q & vec.accept;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            VEC_SCHED_IDLE: begin
                if (head_valid) begin
                    if (head_op.is_lsu) begin
                        if (cnt == '0) begin
                            take    = 1'b1;
                            state_d = VEC_SCHED_HOLD;
                        end else begin
                            state_d = VEC_SCHED_DRAIN;
                        end
                    end else if (cnt < MAX_CNT && !lsu_inflight_q) begin
                        take    = 1'b1;
                        state_d = VEC_SCHED_HOLD;
                    end
                end
            end
            VEC_SCHED_HOLD: begin
                if (issue) begin
                    state_d = VEC_SCHED_IDLE;
                end
            end
            VEC_SCHED_DRAIN: begin
                if (cnt == '0) begin
                    state_d = VEC_SCHED_IDLE;
                end
            end
            default: state_d = VEC_SCHED_IDLE;
        endcase
        if (branch_request_i) begin
            take    = 1'b0;
            state_d = VEC_SCHED_IDLE;
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (take) begin
            buf_valid_d = 1'b1;
            buf_d       = head_op;
        end else if (issue || branch_request_i) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= VEC_SCHED_IDLE;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

    // A flush never cancels an issue already handshaken: that op still completes.
    biriscv_vec_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (issue),
        .dec_i      (vec.done),
        .flag_set_i (issue & buf_q.is_lsu),
        .flag_clr_i (vec.done & (cnt == CW'(1)) & !issue),
        .cnt_o      (cnt),
        .flag_o     (lsu_inflight_q)
    );

    // Accepts are combinational, so mask them while reset is asserted.
    assign lane0_accept_o = take & !head_sel1 & !rst_i;
    assign lane1_accept_o = take &  head_sel1 & !rst_i;

    assign vec.valid  = buf_valid_q;
    assign vec.instr  = buf_q.instr;
    assign vec.pc     = buf_q.pc;
    assign vec.is_lsu = buf_q.is_lsu;

    assign lsu_busy_o = lsu_inflight_q | (buf_valid_q & buf_q.is_lsu);
    assign busy_o     = buf_valid_q | (cnt != '0);

endmodule
